mem_stage: RTL

Memory-access pipeline stage between EX and WB. It consumes the EX-stage `interconnection_struct` bundle, runs loads and stores on the data-memory port with a request/grant/response handshake, and aligns and extends load data. It delivers a registered bundle to WB and stalls EX while a memory access is outstanding.

---
 rtl/mem_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB: request/grant/response data-memory port, lane alignment, load extension.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.

package struct_pckg;
   typedef struct packed {
      logic        is_valid;
      logic [63:0] rf_wr_data;
      logic [63:0] rs2;
      logic [4:0]  rd;
      logic        rf_wr;
      logic        mem_rd;
      logic        mem_wr;
      logic        mem_to_reg;
      logic        mem_ext;
      logic [1:0]  mem_req_unit;
      logic        is_64W;
   } interconnection_struct;
endpackage

module mem_stage
   import struct_pckg::*;
#(
   parameter int XLEN = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  interconnection_struct ex_in,
   output logic                 ex_ready,
   output interconnection_struct wb_out,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [XLEN-1:0]      dmem_addr,
   output logic [7:0]           dmem_be,
   output logic [XLEN-1:0]      dmem_wdata,
   input  logic                 dmem_gnt,
   input  logic                 dmem_rvalid,
   input  logic [XLEN-1:0]      dmem_rdata,
   output logic                 misalign_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                state, state_nxt;
   interconnection_struct hold, hold_nxt;
   interconnection_struct wb_nxt;
   logic                  err_nxt;
   logic [2:0]            off;
   logic [7:0]            be_base;
   logic [XLEN-1:0]       rshift, load_val;
   logic                  accept, is_mem, misal;

   assign ex_ready = (state == IDLE);
   assign accept   = ex_in.is_valid && ex_ready;
   assign is_mem   = ex_in.mem_rd || ex_in.mem_wr;

   // Offset bits below the access size are dropped so the lanes stay inside the doubleword.
   always_comb begin
      off     = hold.rf_wr_data[2:0];
      be_base = 8'hFF;
      case (hold.mem_req_unit)
         2'b00: begin off = hold.rf_wr_data[2:0];         be_base = 8'h01; end
         2'b01: begin off = {hold.rf_wr_data[2:1], 1'b0}; be_base = 8'h03; end
         2'b10: begin off = {hold.rf_wr_data[2], 2'b00};  be_base = 8'h0F; end
         default: begin off = 3'b000;                     be_base = 8'hFF; end
      endcase
   end

   assign dmem_addr  = {hold.rf_wr_data[XLEN-1:3], 3'b000};
   assign dmem_we    = hold.mem_wr;
   assign dmem_be    = be_base << off;
   assign dmem_wdata = hold.rs2 << {off, 3'b000};
   assign rshift     = dmem_rdata >> {off, 3'b000};

   always_comb begin
      load_val = rshift;
      case (hold.mem_req_unit)
         2'b00: load_val = hold.mem_ext ? {56'b0, rshift[7:0]}  : {{56{rshift[7]}}, rshift[7:0]};
         2'b01: load_val = hold.mem_ext ? {48'b0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
         2'b10: load_val = hold.mem_ext ? {32'b0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
         default: load_val = rshift;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      case (ex_in.mem_req_unit)
         2'b01:   misal = ex_in.rf_wr_data[0];
         2'b10:   misal = |ex_in.rf_wr_data[1:0];
         2'b11:   misal = |ex_in.rf_wr_data[2:0];
         default: misal = 1'b0;
      endcase
   end
`else
   assign misal = 1'b0;
`endif

   always_comb begin
      state_nxt       = state;
      hold_nxt        = hold;
      wb_nxt          = wb_out;
      wb_nxt.is_valid = 1'b0;
      err_nxt         = 1'b0;
      dmem_req        = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!is_mem) begin
                  wb_nxt = ex_in;
               end else if (misal) begin
                  wb_nxt       = ex_in;
                  wb_nxt.rf_wr = 1'b0;
                  err_nxt      = 1'b1;
               end else begin
                  hold_nxt  = ex_in;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            dmem_req = 1'b1;
            if (dmem_gnt) begin
               if (hold.mem_wr) begin
                  wb_nxt          = hold;
                  wb_nxt.rf_wr    = 1'b0;
                  wb_nxt.is_valid = 1'b1;
                  state_nxt       = IDLE;
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            if (dmem_rvalid) begin
               wb_nxt          = hold;
               wb_nxt.is_valid = 1'b1;
               if (hold.mem_to_reg) wb_nxt.rf_wr_data = load_val;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         hold   <= '0;
         wb_out <= '0;
      end else begin
         state  <= state_nxt;
         hold   <= hold_nxt;
         wb_out <= wb_nxt;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) misalign_err <= 1'b0;
      else        misalign_err <= err_nxt;
   end
`else
   assign misalign_err = 1'b0;
   logic unused_err;
   assign unused_err = err_nxt;
`endif

endmodule
